pipe_seq_ctrl: RTL and testbench
================================

// Module: pipe_seq_ctrl
// PURPOSE
// Sequencer for serialising instructions (FENCE, FENCE.I, SFENCE.VMA, WFI) held in EXE.
// Stalls the pipeline via seq_hazard (fed to the hazard unit as exe_hazard).
// Drains the LSU, runs I-cache/TLB invalidate handshakes, parks in WFI.
// Ends each sequence with a one-cycle pipe_restart_en pulse and restart_pc.
// PARAMETERS
// XLEN      32   PC width
// DRAIN_TO  256  max cycles in DRAIN before drain_fault; must be >= 2
// PORTS
// clk          in   1     clock
// rst          in   1     async reset, active-high
// req_valid    in   1     serialising instr valid in EXE, not stalled/flushed
// req_type     in   2     seq_pkg::seq_req_e (FENCE=0, FENCE_I=1, SFENCE=2, WFI=3)
// req_pc       in   XLEN  PC of requesting instruction
// sb_empty     in   1     store buffer empty
// lsu_busy     in   1     outstanding load/store in flight
// ic_inv_ack   in   1     I-cache invalidate done (one-cycle pulse)
// tlb_inv_ack  in   1     TLB flush done (one-cycle pulse)
// irq_pending  in   1     any enabled-source interrupt pending (ignores global MIE)
// trap_en      in   1     trap/irq taken this cycle
// seq_hazard   out  1     stall IF..EXE
// ic_inv_req   out  1     level; held until ic_inv_ack
// tlb_inv_req  out  1     level; held until tlb_inv_ack
// irq_block    out  1     defer irq_en while invalidate in progress
// wfi_sleep    out  1     core idle; clock-gate hint
// pipe_restart_en out 1   one-cycle restart pulse to hazard unit/IFU
// restart_pc   out  XLEN  req_pc+4; valid with pipe_restart_en
// drain_fault  out  1     one-cycle pulse on drain timeout
// BEHAVIOUR
// - Reset: state=IDLE, all outputs 0, restart_pc=0, drain_cnt=0. Takes effect mid-sequence.
// - seq_hazard = (state!=IDLE) | (state==IDLE & req_valid) (combinational, same-cycle stall).
// - IDLE: req_valid -> latch req_type, restart_pc=req_pc+4 (mod 2^XLEN); next=DRAIN.
//   - trap_en with req_valid in the same cycle: trap wins; no accept.
// - DRAIN: drain_cnt++ each cycle; exit when sb_empty & ~lsu_busy. Exit is taken even in the
//   same cycle the count expires; drain has priority over timeout.
//   - FENCE -> RESTART; FENCE_I -> IC_INV; SFENCE -> TLB_INV; WFI -> WFI.
//   - drain_cnt==DRAIN_TO-1 and not drained: drain_fault pulse, next=IDLE, no restart.
//   - trap_en: next=IDLE, no restart; drain_cnt cleared.
// - IC_INV / TLB_INV:
//   - req high and irq_block high; trap_en ignored.
//   - On ack -> RESTART; req drops in the RESTART cycle. Ack outside its state ignored.
// - WFI: wfi_sleep=1.
//   - irq_pending -> RESTART.
//   - trap_en -> IDLE; trap_en has priority over irq_pending.
// - RESTART: pipe_restart_en=1 for exactly one cycle, seq_hazard=1; next=IDLE.
//   - The request is not re-accepted in this cycle.
// - Latency: FENCE with LSU already idle: accept at T, DRAIN at T+1, restart pulse at T+2.
// - At most one sequence active; req_valid outside IDLE is ignored (pipeline already stalled).
// STRUCTURE
// - seq_pkg:
//   - seq_req_e
//   - seq_state_e {IDLE, DRAIN, IC_INV, TLB_INV, WFI, RESTART}
//   - DRAIN_CNT_W = $clog2(DRAIN_TO)
// - Sub-module inv_hs (req/ack level-pulse handshake: start, ack -> req, done).
//   - Instantiated twice: ic and tlb.
// - Single always_ff FSM plus counter; outputs decoded from state (registered where listed).
// TESTING
// - FENCE, req_pc=0x8000_0100, sb_empty=1, lsu_busy=0 -> restart pulse at T+2,
//   restart_pc=0x8000_0104, seq_hazard high T..T+2.
// - FENCE_I, lsu_busy 5 cycles then ack 3 cycles after ic_inv_req rises ->
//   ic_inv_req high exactly 3 cycles, irq_block matches, single restart pulse.
// - WFI, irq_pending at +10 -> wfi_sleep high until then, restart next cycle.
//   Repeat with trap_en and irq_pending in the same cycle -> IDLE, no restart.
// - DRAIN_TO=8, sb_empty stuck 0 -> drain_fault at 8th DRAIN cycle, IDLE, no restart;
//   a new req is accepted the next cycle.
// - SFENCE, restart_pc wrap: req_pc=0xFFFF_FFFC -> restart_pc=0x0000_0000 after tlb_inv_ack.
// - rst asserted mid-IC_INV -> outputs 0 asynchronously; a spurious ic_inv_ack after release is ignored.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and helpers for the serialising-instruction sequencer.
package seq_pkg;

  // Serialising instruction class held in EXE.
  typedef enum logic [1:0] {
    REQ_FENCE   = 2'd0,
    REQ_FENCE_I = 2'd1,
    REQ_SFENCE  = 2'd2,
    REQ_WFI     = 2'd3
  } seq_req_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    IC_INV  = 3'd2,
    TLB_INV = 3'd3,
    WFI     = 3'd4,
    RESTART = 3'd5
  } seq_state_e;

  // Width of a counter that must reach to_cycles-1 (to_cycles >= 2).
  function automatic int drain_cnt_w(input int to_cycles);
    return $clog2(to_cycles);
  endfunction

  localparam int DRAIN_TO_DEFAULT = 256;
  localparam int DRAIN_CNT_W      = drain_cnt_w(DRAIN_TO_DEFAULT);

  // Where a sequence goes once the LSU has drained.
  function automatic seq_state_e drain_target(input seq_req_e t);
    seq_state_e s;
    case (t)
      REQ_FENCE_I: s = IC_INV;
      REQ_SFENCE:  s = TLB_INV;
      REQ_WFI:     s = WFI;
      default:     s = RESTART;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/inv_hs.sv
// Level/pulse invalidate handshake: start raises req, the ack pulse drops it.
// An ack arriving while req is low is ignored.
module inv_hs (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic ack_i,
  output logic req_o,
  output logic done_o
);

  logic req_q;

  // Request level: set on start, cleared by the matching ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= 1'b0;
    end else if (start_i) begin
      req_q <= 1'b1;
    end else if (ack_i) begin
      req_q <= 1'b0;
    end
  end

  assign req_o  = req_q;
  assign done_o = req_q & ack_i;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Sequencer for FENCE / FENCE.I / SFENCE.VMA / WFI held in EXE.
// Stalls the front of the pipe, drains the LSU, runs invalidate handshakes
// or parks in WFI, and finishes with a one-cycle restart pulse at req_pc+4.
// Handshakes: ic_inv_req/tlb_inv_req are levels held until a one-cycle ack
// pulse; an ack with no outstanding request has no effect.
module pipe_seq_ctrl
  import seq_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DRAIN_TO = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  seq_req_e        req_type,
  input  logic [XLEN-1:0] req_pc,
  input  logic            sb_empty,
  input  logic            lsu_busy,
  input  logic            ic_inv_ack,
  input  logic            tlb_inv_ack,
  input  logic            irq_pending,
  input  logic            trap_en,
  output logic            seq_hazard,
  output logic            ic_inv_req,
  output logic            tlb_inv_req,
  output logic            irq_block,
  output logic            wfi_sleep,
  output logic            pipe_restart_en,
  output logic [XLEN-1:0] restart_pc,
  output logic            drain_fault,
  output seq_state_e      dbg_state
);

  localparam int               CNT_W    = drain_cnt_w(DRAIN_TO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TO - 1);

  seq_state_e      state_q, state_d;
  seq_req_e        type_q;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [XLEN-1:0] restart_pc_q;

  logic accept;
  logic drained;
  logic drain_timeout;
  logic ic_start, ic_done;
  logic tlb_start, tlb_done;

  assign drained = sb_empty & ~lsu_busy;

  // State register, drain counter and latched request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      type_q       <= REQ_FENCE;
      drain_cnt_q  <= '0;
      restart_pc_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      if (accept) begin
        type_q       <= req_type;
        restart_pc_q <= req_pc + XLEN'(4);
      end
    end
  end

  // Next-state logic; a trap in DRAIN aborts, drain completion beats timeout.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    drain_timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !trap_en) begin
          accept  = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (trap_en) begin
          state_d = IDLE;
        end else if (drained) begin
          state_d = drain_target(type_q);
        end else if (drain_cnt_q == CNT_LAST) begin
          drain_timeout = 1'b1;
          state_d       = IDLE;
        end
      end
      IC_INV: begin
        if (ic_done) state_d = RESTART;
      end
      TLB_INV: begin
        if (tlb_done) state_d = RESTART;
      end
      WFI: begin
        if (trap_en) begin
          state_d = IDLE;
        end else if (irq_pending) begin
          state_d = RESTART;
        end
      end
      RESTART: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    drain_cnt_d = (state_q == DRAIN && state_d == DRAIN) ? drain_cnt_q + 1'b1 : '0;
    ic_start    = (state_q == DRAIN) && (state_d == IC_INV);
    tlb_start   = (state_q == DRAIN) && (state_d == TLB_INV);
  end

  inv_hs u_ic_hs (
    .clk     (clk),
    .rst     (rst),
    .start_i (ic_start),
    .ack_i   (ic_inv_ack),
    .req_o   (ic_inv_req),
    .done_o  (ic_done)
  );

  inv_hs u_tlb_hs (
    .clk     (clk),
    .rst     (rst),
    .start_i (tlb_start),
    .ack_i   (tlb_inv_ack),
    .req_o   (tlb_inv_req),
    .done_o  (tlb_done)
  );

  // Output decode from state; the stall covers the accept cycle combinationally.
  always_comb begin
    seq_hazard      = (state_q != IDLE) | req_valid;
    irq_block       = ic_inv_req | tlb_inv_req;
    wfi_sleep       = (state_q == WFI);
    pipe_restart_en = (state_q == RESTART);
    restart_pc      = restart_pc_q;
    drain_fault     = drain_timeout;
    dbg_state       = state_q;
  end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: per-cycle vector table plus a restart_pc scoreboard.
module tb_pipe_seq_ctrl;
  import seq_pkg::*;

  // Input packing: {rv, type[1:0], sb, busy, ica, tlba, irq, trap}
  localparam logic [8:0] RV    = 9'h100;
  localparam logic [8:0] T_FI  = 9'h040;
  localparam logic [8:0] T_SF  = 9'h080;
  localparam logic [8:0] T_WFI = 9'h0C0;
  localparam logic [8:0] S     = 9'h020;
  localparam logic [8:0] BUSY  = 9'h010;
  localparam logic [8:0] ICA   = 9'h008;
  localparam logic [8:0] TLBA  = 9'h004;
  localparam logic [8:0] IRQ   = 9'h002;
  localparam logic [8:0] TRAP  = 9'h001;
  // Expected output packing: {haz, icr, tlbr, blk, wfi, restart, fault}
  localparam logic [6:0] H   = 7'h40;
  localparam logic [6:0] ICR = 7'h20;
  localparam logic [6:0] TLR = 7'h10;
  localparam logic [6:0] BLK = 7'h08;
  localparam logic [6:0] SLP = 7'h04;
  localparam logic [6:0] RS  = 7'h02;
  localparam logic [6:0] FLT = 7'h01;

  typedef struct {
    logic [8:0]  in;
    logic [6:0]  ex;
    logic [31:0] pc;
    logic        push;
  } vec_t;

  logic        clk, rst;
  logic        req_valid;
  seq_req_e    req_type;
  logic [31:0] req_pc;
  logic        sb_empty, lsu_busy, ic_inv_ack, tlb_inv_ack, irq_pending, trap_en;
  logic        seq_hazard, ic_inv_req, tlb_inv_req, irq_block, wfi_sleep;
  logic        pipe_restart_en, drain_fault;
  logic [31:0] restart_pc;
  seq_state_e  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[$];

  pipe_seq_ctrl #(.XLEN(32), .DRAIN_TO(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_type        (req_type),
    .req_pc          (req_pc),
    .sb_empty        (sb_empty),
    .lsu_busy        (lsu_busy),
    .ic_inv_ack      (ic_inv_ack),
    .tlb_inv_ack     (tlb_inv_ack),
    .irq_pending     (irq_pending),
    .trap_en         (trap_en),
    .seq_hazard      (seq_hazard),
    .ic_inv_req      (ic_inv_req),
    .tlb_inv_req     (tlb_inv_req),
    .irq_block       (irq_block),
    .wfi_sleep       (wfi_sleep),
    .pipe_restart_en (pipe_restart_en),
    .restart_pc      (restart_pc),
    .drain_fault     (drain_fault),
    .dbg_state       (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [8:0] in, input logic [6:0] ex,
                              input logic [31:0] pc, input logic push);
    vec_t v;
    v.in = in; v.ex = ex; v.pc = pc; v.push = push;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {seq_hazard, ic_inv_req, tlb_inv_req, irq_block, wfi_sleep,
            pipe_restart_en, drain_fault};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Driver: called at posedge+1, checks at negedge, returns at next posedge+1.
  task automatic drive(input vec_t v, input string tag);
    logic [1:0] t;
    t           = v.in[7:6];
    req_valid   = v.in[8];
    req_type    = seq_req_e'(t);
    req_pc      = v.pc;
    sb_empty    = v.in[5];
    lsu_busy    = v.in[4];
    ic_inv_ack  = v.in[3];
    tlb_inv_ack = v.in[2];
    irq_pending = v.in[1];
    trap_en     = v.in[0];
    if (v.push) exp_q.push_back(v.pc + 32'd4);
    @(negedge clk);
    check(tag, 32'(outs()), 32'(v.ex));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every restart pulse must match the oldest expected restart_pc.
  always @(negedge clk) begin
    if (!rst && pipe_restart_en) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_restart: got pc %h want no pulse", restart_pc);
      end else begin
        check("restart_pc", restart_pc, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_type = REQ_FENCE; req_pc = '0;
    sb_empty = 1'b1; lsu_busy = 1'b0; ic_inv_ack = 1'b0; tlb_inv_ack = 1'b0;
    irq_pending = 1'b0; trap_en = 1'b0;

    // FENCE, LSU idle: accept T, drain T+1, restart T+2; req in RESTART ignored
    vecs.push_back(mk(RV|S,      H,    32'h8000_0100, 1'b1));
    vecs.push_back(mk(S,         H,    32'h0,         1'b0));
    vecs.push_back(mk(RV|S,      H|RS, 32'h0,         1'b0));
    vecs.push_back(mk(S,         7'h0, 32'h0,         1'b0));
    // trap in the accept cycle wins; stray acks in IDLE do nothing
    vecs.push_back(mk(RV|S|TRAP, H,    32'h1111_0000, 1'b0));
    vecs.push_back(mk(S|ICA|TLBA, 7'h0, 32'h0,        1'b0));
    // FENCE_I: LSU busy 5 drain cycles, ack in third req cycle
    vecs.push_back(mk(RV|T_FI|S, H, 32'h0000_1000, 1'b1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(S|BUSY, H, 32'h0, 1'b0));
    vecs.push_back(mk(S,     H,           32'h0, 1'b0));
    vecs.push_back(mk(S,     H|ICR|BLK,   32'h0, 1'b0));
    vecs.push_back(mk(S,     H|ICR|BLK,   32'h0, 1'b0));
    vecs.push_back(mk(S|ICA, H|ICR|BLK,   32'h0, 1'b0));
    vecs.push_back(mk(S,     H|RS,        32'h0, 1'b0));
    vecs.push_back(mk(S,     7'h0,        32'h0, 1'b0));
    // WFI woken by irq_pending on the 10th sleep cycle
    vecs.push_back(mk(RV|T_WFI|S, H, 32'h0000_2000, 1'b1));
    vecs.push_back(mk(S, H, 32'h0, 1'b0));
    for (int i = 0; i < 9; i++) vecs.push_back(mk(S, H|SLP, 32'h0, 1'b0));
    vecs.push_back(mk(S|IRQ, H|SLP, 32'h0, 1'b0));
    vecs.push_back(mk(S,     H|RS,  32'h0, 1'b0));
    vecs.push_back(mk(S,     7'h0,  32'h0, 1'b0));
    // WFI with trap and irq together: back to IDLE, no restart
    vecs.push_back(mk(RV|T_WFI|S, H, 32'h0000_3000, 1'b0));
    vecs.push_back(mk(S, H, 32'h0, 1'b0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(S, H|SLP, 32'h0, 1'b0));
    vecs.push_back(mk(S|IRQ|TRAP, H|SLP, 32'h0, 1'b0));
    vecs.push_back(mk(S,          7'h0,  32'h0, 1'b0));
    // drain timeout (DRAIN_TO=8): fault on 8th drain cycle, then a fresh accept
    vecs.push_back(mk(RV, H, 32'h0000_4000, 1'b0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(9'h0, H, 32'h0, 1'b0));
    vecs.push_back(mk(9'h0, H|FLT, 32'h0, 1'b0));
    vecs.push_back(mk(RV|S, H,     32'h0000_5000, 1'b1));
    vecs.push_back(mk(S,    H,     32'h0, 1'b0));
    vecs.push_back(mk(S,    H|RS,  32'h0, 1'b0));
    vecs.push_back(mk(S,    7'h0,  32'h0, 1'b0));
    // drain completes in the same cycle the count expires: restart, no fault
    vecs.push_back(mk(RV, H, 32'h0000_7000, 1'b1));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(9'h0, H, 32'h0, 1'b0));
    vecs.push_back(mk(S, H,    32'h0, 1'b0));
    vecs.push_back(mk(S, H|RS, 32'h0, 1'b0));
    vecs.push_back(mk(S, 7'h0, 32'h0, 1'b0));
    // trap in DRAIN aborts; the next drain starts its count from zero
    vecs.push_back(mk(RV,   H,    32'h0000_7100, 1'b0));
    vecs.push_back(mk(9'h0, H,    32'h0, 1'b0));
    vecs.push_back(mk(TRAP, H,    32'h0, 1'b0));
    vecs.push_back(mk(S,    7'h0, 32'h0, 1'b0));
    vecs.push_back(mk(RV,   H,    32'h0000_7200, 1'b0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(9'h0, H, 32'h0, 1'b0));
    vecs.push_back(mk(9'h0, H|FLT, 32'h0, 1'b0));
    vecs.push_back(mk(S,    7'h0,  32'h0, 1'b0));
    // SFENCE with PC wrap; stray ic ack and trap ignored during TLB_INV
    vecs.push_back(mk(RV|T_SF|S, H, 32'hFFFF_FFFC, 1'b1));
    vecs.push_back(mk(S,      H,         32'h0, 1'b0));
    vecs.push_back(mk(S|ICA,  H|TLR|BLK, 32'h0, 1'b0));
    vecs.push_back(mk(S|TRAP, H|TLR|BLK, 32'h0, 1'b0));
    vecs.push_back(mk(S|TLBA, H|TLR|BLK, 32'h0, 1'b0));
    vecs.push_back(mk(S,      H|RS,      32'h0, 1'b0));
    vecs.push_back(mk(S,      7'h0,      32'h0, 1'b0));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 32'(outs()), 32'h0);
    check("reset_pc", restart_pc, 32'h0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) drive(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted mid-IC_INV clears outputs without a clock edge
    drive(mk(RV|T_FI|S, H, 32'h0000_6000, 1'b0), "rstseq_accept");
    drive(mk(S,         H, 32'h0,         1'b0), "rstseq_drain");
    #2;
    check("rstseq_icreq", 32'(ic_inv_req), 32'h1);
    rst = 1'b1;
    #1;
    check("rstseq_async_outs", 32'(outs()), 32'h0);
    check("rstseq_async_pc", restart_pc, 32'h0);
    check("rstseq_async_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(mk(S|ICA, 7'h0, 32'h0, 1'b0), "rstseq_spurious_ack");
    drive(mk(S,     7'h0, 32'h0, 1'b0), "rstseq_idle");

    check("sb_leftover", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
